// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared opcodes, exception codes, FSM states and decode helpers
//               for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  // Memory operation codes carried on ex_aluop
  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  // Exception codes reported on excp_code
  localparam logic [1:0] EXCP_MISALIGN = 2'b01;
  localparam logic [1:0] EXCP_BUS_ERR  = 2'b10;
  localparam logic [1:0] EXCP_TIMEOUT  = 2'b11;

  // ST_DRAIN finishes a flushed transfer without reporting its result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUS   = 2'b01,
    ST_DRAIN = 2'b10
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
      default:                         is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    is_store_op = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned
  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: is_misaligned = lo[0];
      EXE_LW_OP, EXE_SW_OP:             is_misaligned = |lo;
      default:                          is_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_align
// Description : Combinational byte-lane logic: store lane enables and data
//               replication, plus load lane extraction and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [7:0]        op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        sel_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane(s) of the read word
  assign w_byte = 8'(rdata_i >> {addr_lo_i, 3'b000});
  assign w_half = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});

  // Lane enables and replicated store data; loads use the same lane map
  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = '0;
    case (op_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        sel_o   = 4'b1111;
        wdata_o = store_data_i;
      end
      default: ;
    endcase
  end

  // Sign- or zero-extend the selected load lane
  always_comb begin
    load_data_o = '0;
    case (op_i)
      EXE_LB_OP:  load_data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
      EXE_LBU_OP: load_data_o = {{(DATA_W-8){1'b0}}, w_byte};
      EXE_LH_OP:  load_data_o = {{(DATA_W-16){w_half[15]}}, w_half};
      EXE_LHU_OP: load_data_o = {{(DATA_W-16){1'b0}}, w_half};
      EXE_LW_OP:  load_data_o = rdata_i;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Memory-access pipeline stage. Passes ALU results through with
//               one cycle of latency and runs single-beat req/ack bus cycles
//               for loads and stores, reporting misalignment, bus error and
//               bus timeout as exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  input  logic [7:0]            ex_aluop_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic [ADDR_W-1:0]     ex_mem_addr_i,
  input  logic [DATA_W-1:0]     ex_store_data_i,
  output logic                  stallreq_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic                  bus_err_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_wd_o,
  output logic                  wb_wreg_o,
  output logic [DATA_W-1:0]     wb_wdata_o,
  output logic                  excp_o,
  output logic [1:0]            excp_code_o,
  output logic [ADDR_W-1:0]     excp_addr_o
);

  // Last bus_req cycle index before a timeout abort
  localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

  lsu_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [3:0]            bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_wd_q, wb_wd_d;
  logic                  wb_wreg_q, wb_wreg_d;
  logic [DATA_W-1:0]     wb_wdata_q, wb_wdata_d;
  logic                  excp_q, excp_d;
  logic [1:0]            excp_code_q, excp_code_d;
  logic [ADDR_W-1:0]     excp_addr_q, excp_addr_d;

  logic [7:0]            w_align_op;
  logic [1:0]            w_align_lo;
  logic [3:0]            w_sel;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_load_data;
  logic                  w_term;

  // One lane unit serves both phases: the incoming op in IDLE, the captured op on the bus
  assign w_align_op = (state_q == ST_IDLE) ? ex_aluop_i : op_q;
  assign w_align_lo = (state_q == ST_IDLE) ? ex_mem_addr_i[1:0] : addr_q[1:0];

  mem_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .op_i         (w_align_op),
    .addr_lo_i    (w_align_lo),
    .store_data_i (ex_store_data_i),
    .rdata_i      (bus_rdata_i),
    .sel_o        (w_sel),
    .wdata_o      (w_wdata),
    .load_data_o  (w_load_data)
  );

  assign w_term = bus_ack_i | bus_err_i | (cnt_q == c_to_last);

  // Next-state and output decode; every pulse output defaults low
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    addr_d      = addr_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wb_wd_d     = wb_wd_q;
    wb_wreg_d   = wb_wreg_q;
    wb_wdata_d  = wb_wdata_q;
    excp_d      = 1'b0;
    excp_code_d = excp_code_q;
    excp_addr_d = excp_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i && !flush_i) begin
          if (!is_mem_op(ex_aluop_i)) begin
            wb_valid_d = 1'b1;
            wb_wd_d    = ex_wd_i;
            wb_wreg_d  = ex_wreg_i;
            wb_wdata_d = ex_wdata_i;
          end else if (is_misaligned(ex_aluop_i, ex_mem_addr_i[1:0])) begin
            excp_d      = 1'b1;
            excp_code_d = EXCP_MISALIGN;
            excp_addr_d = ex_mem_addr_i;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = 8'd0;
            op_d        = ex_aluop_i;
            wd_d        = ex_wd_i;
            wreg_d      = ex_wreg_i;
            addr_d      = ex_mem_addr_i;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store_op(ex_aluop_i);
            bus_addr_d  = {ex_mem_addr_i[ADDR_W-1:2], 2'b00};
            bus_sel_d   = w_sel;
            bus_wdata_d = w_wdata;
          end
        end
      end
      ST_BUS, ST_DRAIN: begin
        if (w_term) begin
          state_d   = ST_IDLE;
          cnt_d     = 8'd0;
          bus_req_d = 1'b0;
          // A flush on the terminating cycle still discards the result
          if (state_q == ST_BUS && !flush_i) begin
            if (bus_err_i) begin
              excp_d      = 1'b1;
              excp_code_d = EXCP_BUS_ERR;
              excp_addr_d = addr_q;
            end else if (bus_ack_i) begin
              wb_valid_d = 1'b1;
              wb_wd_d    = wd_q;
              if (is_store_op(op_q)) begin
                wb_wreg_d = 1'b0;
              end else begin
                wb_wreg_d  = wreg_q;
                wb_wdata_d = w_load_data;
              end
            end else begin
              excp_d      = 1'b1;
              excp_code_d = EXCP_TIMEOUT;
              excp_addr_d = addr_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush_i) begin
            state_d = ST_DRAIN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      addr_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_wd_q     <= '0;
      wb_wreg_q   <= 1'b0;
      wb_wdata_q  <= '0;
      excp_q      <= 1'b0;
      excp_code_q <= '0;
      excp_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      addr_q      <= addr_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_wd_q     <= wb_wd_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_wdata_q  <= wb_wdata_d;
      excp_q      <= excp_d;
      excp_code_q <= excp_code_d;
      excp_addr_q <= excp_addr_d;
    end
  end

  assign stallreq_o  = (state_q != ST_IDLE);
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_wd_o     = wb_wd_q;
  assign wb_wreg_o   = wb_wreg_q;
  assign wb_wdata_o  = wb_wdata_q;
  assign excp_o      = excp_q;
  assign excp_code_o = excp_code_q;
  assign excp_addr_o = excp_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu: directed scenarios plus a
//               randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

  localparam int TO = 4;
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5;
  localparam logic [7:0] LW = 8'hE3, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;
  localparam logic [7:0] ADDOP = 8'h21;

  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, ex_wreg, bus_ack, bus_err;
  logic [7:0]  ex_aluop;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_mem_addr, ex_store_data, bus_rdata;
  logic        stallreq, bus_req, bus_we, wb_valid, wb_wreg, excp;
  logic [31:0] bus_addr, bus_wdata, wb_wdata, excp_addr;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;
  logic [1:0]  excp_code;

  int total = 0;
  int bad   = 0;

  // observations gathered by do_op
  int          o_req, o_stall, o_wb, o_ex, o_both, o_wb_lat, o_ex_lat;
  logic        o_we, o_stable, o_wreg;
  logic [31:0] o_baddr, o_bwdata, o_wdata, o_eaddr;
  logic [3:0]  o_sel;
  logic [4:0]  o_wd;
  logic [1:0]  o_code;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_aluop_i(ex_aluop),
    .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg), .ex_wdata_i(ex_wdata), .ex_mem_addr_i(ex_mem_addr),
    .ex_store_data_i(ex_store_data), .stallreq_o(stallreq), .bus_req_o(bus_req),
    .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_sel_o(bus_sel), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata), .wb_valid_o(wb_valid),
    .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata), .excp_o(excp),
    .excp_code_o(excp_code), .excp_addr_o(excp_addr)
  );

  // Presents one bundle for one cycle, then plays the bus slave for 12 cycles:
  // response on BUS cycle ack_after+1, flush on BUS cycle flush_at (0 = none).
  task automatic do_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int ack_after, input logic ack,
                       input logic err, input int flush_at);
    int req;
    req = 0; o_stall = 0; o_wb = 0; o_ex = 0; o_both = 0; o_wb_lat = 0; o_ex_lat = 0;
    o_stable = 1'b1; o_we = 1'b0; o_baddr = '0; o_sel = '0; o_bwdata = '0;
    ex_valid = 1'b1; ex_aluop = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_mem_addr = addr; ex_store_data = sdata;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0; bus_rdata = $urandom;
      if (stallreq) o_stall++;
      if (bus_req) begin
        req++;
        if (req == 1) begin
          o_we = bus_we; o_baddr = bus_addr; o_sel = bus_sel; o_bwdata = bus_wdata;
        end else if ({bus_we, bus_addr, bus_sel, bus_wdata} !== {o_we, o_baddr, o_sel, o_bwdata}) begin
          o_stable = 1'b0;
        end
        if (req == ack_after + 1) begin
          bus_ack = ack; bus_err = err; bus_rdata = rdata;
        end
        if (req == flush_at) flush = 1'b1;
      end
      if (wb_valid) begin
        o_wb++;
        if (o_wb == 1) begin
          o_wb_lat = n; o_wd = wb_wd; o_wreg = wb_wreg; o_wdata = wb_wdata;
        end
      end
      if (excp) begin
        o_ex++;
        if (o_ex == 1) begin
          o_ex_lat = n; o_code = excp_code; o_eaddr = excp_addr;
        end
      end
      if (wb_valid && excp) o_both++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
    o_req = req;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_aluop = '0; ex_wd = '0; ex_wreg = 1'b0;
    ex_wdata = '0; ex_mem_addr = '0; ex_store_data = '0; bus_ack = 1'b0; bus_err = 1'b0;
    bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({stallreq, bus_req, bus_we, bus_addr, bus_sel, bus_wdata, wb_valid, wb_wd, wb_wreg,
         wb_wdata, excp, excp_code, excp_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: some output nonzero (bus_req=%b wb_valid=%b excp=%b stall=%b), required all 0",
               bus_req, wb_valid, excp, stallreq);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_quiet();
    int seen;
    seen = 0;
    ex_aluop = ADDOP; ex_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen += int'(wb_valid) + int'(excp); end
    ex_valid = 1'b1; flush = 1'b1; ex_aluop = LW; ex_mem_addr = 32'h301;
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0;
    repeat (3) begin seen += int'(wb_valid) + int'(excp) + int'(bus_req); @(posedge clk); #1; end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL idle_quiet: %0d pulses seen, required 0", seen);
    end
  endtask

  task automatic test_passthrough();
    do_op(ADDOP, 5'd3, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 99, 1'b1, 1'b0, 0);
    total++;
    if ({o_wb, o_wb_lat, o_wd, o_wreg, o_wdata} !== {32'd1, 32'd1, 5'd3, 1'b1, 32'h1234_5678}) begin
      bad++; $display("FAIL passthrough_wb: cnt=%0d lat=%0d wd=%0d wreg=%b data=%h, required 1/1/3/1/12345678",
                      o_wb, o_wb_lat, o_wd, o_wreg, o_wdata);
    end
    total++;
    if ({o_stall, o_req, o_ex} !== {32'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL passthrough_stall: stall=%0d req=%0d excp=%0d, required 0/0/0", o_stall, o_req, o_ex);
    end
  endtask

  task automatic test_load_byte();
    do_op(LB, 5'd7, 1'b1, 32'h0, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b1, 1'b0, 0);
    total++;
    if ({o_baddr, o_sel, o_we, o_req} !== {32'h100, 4'b1000, 1'b0, 32'd1}) begin
      bad++; $display("FAIL lb_bus: addr=%h sel=%b we=%b req=%0d, required 100/1000/0/1", o_baddr, o_sel, o_we, o_req);
    end
    total++;
    if ({o_wb, o_wb_lat, o_wdata, o_wreg} !== {32'd1, 32'd2, 32'hFFFF_FF80, 1'b1}) begin
      bad++; $display("FAIL lb_wb: cnt=%0d lat=%0d data=%h wreg=%b, required 1/2/ffffff80/1", o_wb, o_wb_lat, o_wdata, o_wreg);
    end
    do_op(LBU, 5'd7, 1'b1, 32'h0, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b1, 1'b0, 0);
    total++;
    if ({o_wb, o_wb_lat, o_wdata} !== {32'd1, 32'd2, 32'h0000_0080}) begin
      bad++; $display("FAIL lbu_wb: cnt=%0d lat=%0d data=%h, required 1/2/00000080", o_wb, o_wb_lat, o_wdata);
    end
  endtask

  task automatic test_store_half();
    do_op(SH, 5'd9, 1'b1, 32'h0, 32'h202, 32'hAAAA_BEEF, 32'h0, 3, 1'b1, 1'b0, 0);
    total++;
    if ({o_sel, o_bwdata, o_we, o_baddr, o_stable} !== {4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h200, 1'b1}) begin
      bad++; $display("FAIL sh_bus: sel=%b wdata=%h we=%b addr=%h stable=%b, required 1100/beefbeef/1/200/1",
                      o_sel, o_bwdata, o_we, o_baddr, o_stable);
    end
    total++;
    if ({o_stall, o_req, o_wb, o_wreg, o_wb_lat} !== {32'd4, 32'd4, 32'd1, 1'b0, 32'd5}) begin
      bad++; $display("FAIL sh_wb: stall=%0d req=%0d wb=%0d wreg=%b lat=%0d, required 4/4/1/0/5",
                      o_stall, o_req, o_wb, o_wreg, o_wb_lat);
    end
  endtask

  task automatic test_misaligned_and_err();
    do_op(LW, 5'd1, 1'b1, 32'h0, 32'h301, 32'h0, 32'h0, 0, 1'b1, 1'b0, 0);
    total++;
    if ({o_ex, o_ex_lat, o_code, o_eaddr, o_req, o_wb} !== {32'd1, 32'd1, 2'b01, 32'h301, 32'd0, 32'd0}) begin
      bad++; $display("FAIL misalign: excp=%0d lat=%0d code=%b addr=%h req=%0d wb=%0d, required 1/1/01/301/0/0",
                      o_ex, o_ex_lat, o_code, o_eaddr, o_req, o_wb);
    end
    do_op(LW, 5'd1, 1'b1, 32'h0, 32'h400, 32'h0, 32'h5555_5555, 1, 1'b1, 1'b1, 0);
    total++;
    if ({o_ex, o_code, o_eaddr, o_wb, o_ex_lat} !== {32'd1, 2'b10, 32'h400, 32'd0, 32'd3}) begin
      bad++; $display("FAIL bus_err: excp=%0d code=%b addr=%h wb=%0d lat=%0d, required 1/10/400/0/3",
                      o_ex, o_code, o_eaddr, o_wb, o_ex_lat);
    end
  endtask

  task automatic test_timeout();
    do_op(LW, 5'd2, 1'b1, 32'h0, 32'h508, 32'h0, 32'h0, 99, 1'b1, 1'b0, 0);
    total++;
    if ({o_req, o_ex, o_code, o_eaddr, o_ex_lat, o_wb} !== {32'd4, 32'd1, 2'b11, 32'h508, 32'd5, 32'd0}) begin
      bad++; $display("FAIL timeout: req=%0d excp=%0d code=%b addr=%h lat=%0d wb=%0d, required 4/1/11/508/5/0",
                      o_req, o_ex, o_code, o_eaddr, o_ex_lat, o_wb);
    end
    total++;
    if (stallreq !== 1'b0) begin
      bad++; $display("FAIL timeout_idle: stallreq=%b, required 0", stallreq);
    end
  endtask

  task automatic test_flush();
    do_op(LW, 5'd4, 1'b1, 32'h0, 32'h600, 32'h0, 32'h1111_2222, 3, 1'b1, 1'b0, 2);
    total++;
    if ({o_req, o_wb, o_ex, o_stall} !== {32'd4, 32'd0, 32'd0, 32'd4}) begin
      bad++; $display("FAIL flush_bus: req=%0d wb=%0d excp=%0d stall=%0d, required 4/0/0/4", o_req, o_wb, o_ex, o_stall);
    end
  endtask

  task automatic test_reset_mid_bus();
    int seen;
    seen = 0;
    ex_valid = 1'b1; ex_aluop = LW; ex_mem_addr = 32'h700; ex_wd = 5'd5; ex_wreg = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({stallreq, bus_req, bus_we, bus_addr, bus_sel, bus_wdata, wb_valid, wb_wd, wb_wreg,
         wb_wdata, excp, excp_code, excp_addr} !== '0) begin
      bad++; $display("FAIL reset_mid_bus: bus_req=%b stall=%b addr=%h, required all outputs 0", bus_req, stallreq, bus_addr);
    end
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    repeat (2) begin seen += int'(wb_valid) + int'(excp) + int'(bus_req); @(posedge clk); #1; end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL late_ack: %0d activity cycles, required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [7:0]  ops [9];
    logic [7:0]  op;
    logic [31:0] addr, sdata, rdata, lane, exp_data, exp_wdata;
    logic [4:0]  wd;
    logic        wreg, ack, err, ismem, isst, mis, sgn, flushed, resp;
    int          size, ack_after, flush_at, cyc, kind;
    logic [3:0]  exp_sel;
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, ADDOP};
    for (int it = 0; it < 60; it++) begin
      op = ops[$urandom_range(0, 8)];
      addr = $urandom & 32'h0000_FFFF; sdata = $urandom; rdata = $urandom;
      wd = 5'($urandom); wreg = 1'($urandom);
      ack_after = $urandom_range(0, 5);
      kind = $urandom_range(0, 3);
      ack = (kind != 1); err = (kind >= 2);
      flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_op(op, wd, wreg, sdata, addr, sdata, rdata, ack_after, ack, err, flush_at);
      ismem = (op != ADDOP);
      isst = (op == SB) || (op == SH) || (op == SW);
      sgn = (op == LB) || (op == LH);
      size = (op == LB || op == LBU || op == SB) ? 1 : (op == LW || op == SW) ? 4 : 2;
      mis = ismem && (addr % size != 0);
      total++;
      if (o_both !== 0) begin
        bad++; $display("FAIL rnd_both[%0d]: wb and excp together %0d times, required 0", it, o_both);
      end
      if (!ismem) begin
        total++;
        if ({o_wb, o_wb_lat, o_wd, o_wreg, o_wdata, o_req} !== {32'd1, 32'd1, wd, wreg, sdata, 32'd0}) begin
          bad++; $display("FAIL rnd_pass[%0d]: wb=%0d lat=%0d data=%h req=%0d, required 1/1/%h/0", it, o_wb, o_wb_lat, o_wdata, o_req, sdata);
        end
      end else if (mis) begin
        total++;
        if ({o_ex, o_ex_lat, o_code, o_eaddr, o_req, o_wb} !== {32'd1, 32'd1, 2'b01, addr, 32'd0, 32'd0}) begin
          bad++; $display("FAIL rnd_mis[%0d]: excp=%0d code=%b addr=%h req=%0d, required 1/01/%h/0", it, o_ex, o_code, o_eaddr, o_req, addr);
        end
      end else begin
        resp = (ack_after < TO) && (ack || err);
        cyc = resp ? ack_after + 1 : TO;
        flushed = (flush_at >= 1) && (flush_at <= cyc);
        exp_sel = (size == 4) ? 4'hF : 4'((size == 1 ? 1 : 3) << (addr % 4));
        exp_wdata = (size == 1) ? (sdata % 256) * 32'h0101_0101 :
                    (size == 2) ? (sdata % 65536) * 32'h0001_0001 : sdata;
        total++;
        if ({o_req, o_stall, o_baddr, o_sel, o_we, o_stable} !== {cyc, cyc, addr - addr % 4, exp_sel, isst, 1'b1}) begin
          bad++; $display("FAIL rnd_bus[%0d] op=%h: req=%0d addr=%h sel=%b we=%b stable=%b, required %0d/%h/%b/%b/1",
                          it, op, o_req, o_baddr, o_sel, o_we, o_stable, cyc, addr - addr % 4, exp_sel, isst);
        end
        if (isst) begin
          total++;
          if (o_bwdata !== exp_wdata) begin
            bad++; $display("FAIL rnd_wdata[%0d]: %h, required %h", it, o_bwdata, exp_wdata);
          end
        end
        total++;
        if (flushed) begin
          if ({o_wb, o_ex} !== {32'd0, 32'd0}) begin
            bad++; $display("FAIL rnd_flush[%0d]: wb=%0d excp=%0d, required 0/0", it, o_wb, o_ex);
          end
        end else if (resp && err) begin
          if ({o_ex, o_code, o_eaddr, o_ex_lat, o_wb} !== {32'd1, 2'b10, addr, cyc + 1, 32'd0}) begin
            bad++; $display("FAIL rnd_err[%0d]: excp=%0d code=%b addr=%h lat=%0d wb=%0d", it, o_ex, o_code, o_eaddr, o_ex_lat, o_wb);
          end
        end else if (resp) begin
          lane = rdata >> (8 * (addr % 4));
          if (size == 1) exp_data = (sgn && lane[7]) ? (lane % 256) + 32'hFFFF_FF00 : lane % 256;
          else if (size == 2) exp_data = (sgn && lane[15]) ? (lane % 65536) + 32'hFFFF_0000 : lane % 65536;
          else exp_data = rdata;
          if ({o_wb, o_ex, o_wb_lat, o_wd, o_wreg} !== {32'd1, 32'd0, cyc + 1, wd, isst ? 1'b0 : wreg} ||
              (!isst && o_wdata !== exp_data)) begin
            bad++; $display("FAIL rnd_wb[%0d] op=%h: wb=%0d lat=%0d wreg=%b data=%h, required lat %0d data %h",
                            it, op, o_wb, o_wb_lat, o_wreg, o_wdata, cyc + 1, exp_data);
          end
        end else begin
          if ({o_ex, o_code, o_eaddr, o_ex_lat, o_wb} !== {32'd1, 2'b11, addr, TO + 1, 32'd0}) begin
            bad++; $display("FAIL rnd_tmo[%0d]: excp=%0d code=%b addr=%h lat=%0d wb=%0d", it, o_ex, o_code, o_eaddr, o_ex_lat, o_wb);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_quiet();
    test_passthrough();
    test_load_byte();
    test_store_half();
    test_misaligned_and_err();
    test_timeout();
    test_flush();
    test_reset_mid_bus();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
